// File: rtl/rdc_regs_pkg.sv
// Shared constants for the RDC error register block.
// Holds the register addresses, threshold reset values, ID, error bit indices and CLEAR_ALL bit.
// Contains no logic, so latency and backpressure do not apply.
package rdc_regs_pkg;

   // Register map. The top level casts these to ADDR_WIDTH.
   localparam logic [7:0] ADDR_ID            = 8'h00;
   localparam logic [7:0] ADDR_LOS_THRESH    = 8'h01;
   localparam logic [7:0] ADDR_DOS_OVERRANGE = 8'h02;
   localparam logic [7:0] ADDR_DOS_MISMATCH  = 8'h03;
   localparam logic [7:0] ADDR_DOS_MAX       = 8'h04;
   localparam logic [7:0] ADDR_DOS_MIN       = 8'h05;
   localparam logic [7:0] ADDR_ENABLE_MASK   = 8'h06;
   localparam logic [7:0] ADDR_ERROR_CLEAR   = 8'h07;
   localparam logic [7:0] ADDR_STATUS        = 8'h08;
   localparam logic [7:0] ADDR_FIRST_FAULT   = 8'h09;
   localparam logic [7:0] ADDR_EVENT_COUNT   = 8'h0A;

   // Threshold reset values. Each one fits in a 14-bit ADC range.
   localparam logic [13:0] LOS_THRESH_RST    = 14'h0100;
   localparam logic [13:0] DOS_OVERRANGE_RST = 14'h1FFF;
   localparam logic [13:0] DOS_MISMATCH_RST  = 14'h1000;
   localparam logic [13:0] DOS_MAX_RST       = 14'h0000;
   localparam logic [13:0] DOS_MIN_RST       = 14'h1FFF;

   localparam logic [31:0] ID_VALUE_DEFAULT = 32'h1234_5678;

   // Error source bit positions in error_event_i, STATUS and error_o.
   localparam int ERR_CLIP      = 0;
   localparam int ERR_LOS       = 1;
   localparam int ERR_OVERRANGE = 2;
   localparam int ERR_MISMATCH  = 3;

   // When this bit is set in an ERROR_CLEAR write, FIRST_FAULT and EVENT_COUNT are also reset.
   localparam int CLEAR_ALL_BIT = 31;

   localparam int EVENT_COUNT_WIDTH = 16;

endpackage

// File: rtl/rdc_error_regs_latch.sv
// Sticky error latch with first-fault capture and a saturating new-event counter.
// Latency: an event or clear updates the state on the edge that samples it.
// Backpressure: none. Events are absorbed on every cycle.
// Ports: event_i (raw flags), mask_i (enable mask), clr_i (per-bit clear), clr_all_i (resets
//   first-fault and count); sticky_o, first_fault_o, event_count_o (register state).
module error_latch_bank
   import rdc_regs_pkg::*;
#(
   parameter int NUM_ERRORS  = 8,
   parameter int COUNT_WIDTH = EVENT_COUNT_WIDTH
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic [NUM_ERRORS-1:0]  event_i,
   input  logic [NUM_ERRORS-1:0]  mask_i,
   input  logic [NUM_ERRORS-1:0]  clr_i,
   input  logic                   clr_all_i,
   output logic [NUM_ERRORS-1:0]  sticky_o,
   output logic [NUM_ERRORS-1:0]  first_fault_o,
   output logic [COUNT_WIDTH-1:0] event_count_o
);

   logic [NUM_ERRORS-1:0]  sticky_q;
   logic [NUM_ERRORS-1:0]  first_fault_q;
   logic [COUNT_WIDTH-1:0] count_q;
   logic [NUM_ERRORS-1:0]  new_event;
   logic                   any_new;

   // An event counts as new only if it is enabled and its sticky bit is not already set.
   // The sticky value used here is the one from before this edge's update.
   assign new_event = event_i & mask_i & ~sticky_q;
   assign any_new   = |new_event;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sticky_q      <= '0;
         first_fault_q <= '0;
         count_q       <= '0;
      end else begin
         // The event term is ORed in last, so a set beats a clear on the same bit.
         sticky_q <= (sticky_q & ~clr_i) | event_i;
         if (clr_all_i) begin
            // A new event in the same cycle as clear-all becomes the new history.
            first_fault_q <= new_event;
            count_q       <= any_new ? COUNT_WIDTH'(1) : '0;
         end else begin
            if (first_fault_q == '0)
               first_fault_q <= new_event;
            if (any_new && (count_q != '1))
               count_q <= count_q + COUNT_WIDTH'(1);
         end
      end
   end

   assign sticky_o      = sticky_q;
   assign first_fault_o = first_fault_q;
   assign event_count_o = count_q;

endmodule

// File: rtl/rdc_error_regs.sv
// Register responder for the RDC error subsystem: thresholds, mask, sticky status, diagnostics.
// Latency: writes act on the sampling edge, reads are combinational, error_o lags sticky by 1 cycle.
// Backpressure: none. Every strobe is accepted in the cycle it is presented.
// Ports: clk_i/reset_i; reg_addr_i, reg_data_i, reg_write_i, reg_read_i, reg_data_o (host bus);
//   error_event_i (detector flags); *_thresh_o, cfg_update_o (config); error_o (masked status).
module rdc_error_regs
   import rdc_regs_pkg::*;
#(
   parameter int                    ADDR_WIDTH   = 8,
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    THRESH_WIDTH = 14,
   parameter int                    NUM_ERRORS   = 8,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE     = 32'h1234_5678
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic [ADDR_WIDTH-1:0]   reg_addr_i,
   input  logic [DATA_WIDTH-1:0]   reg_data_i,
   input  logic                    reg_write_i,
   input  logic                    reg_read_i,
   output logic [DATA_WIDTH-1:0]   reg_data_o,
   input  logic [NUM_ERRORS-1:0]   error_event_i,
   output logic [THRESH_WIDTH-1:0] los_thresh_o,
   output logic [THRESH_WIDTH-1:0] dos_overrange_thresh_o,
   output logic [THRESH_WIDTH-1:0] dos_mismatch_thresh_o,
   output logic [THRESH_WIDTH-1:0] dos_max_thresh_o,
   output logic [THRESH_WIDTH-1:0] dos_min_thresh_o,
   output logic                    cfg_update_o,
   output logic [NUM_ERRORS-1:0]   error_o
);

   logic [THRESH_WIDTH-1:0] los_q, ovr_q, mis_q, max_q, min_q;
   logic [NUM_ERRORS-1:0]   mask_q;
   logic [NUM_ERRORS-1:0]   error_q;
   logic                    cfg_update_q;

   logic wr_los, wr_ovr, wr_mis, wr_max, wr_min, wr_mask, wr_clear;
   logic [NUM_ERRORS-1:0]   clr;
   logic                    clr_all;

   logic [NUM_ERRORS-1:0]        sticky;
   logic [NUM_ERRORS-1:0]        first_fault;
   logic [EVENT_COUNT_WIDTH-1:0] event_count;

   // Write decode. Read-only and unmapped addresses have no strobe, so writes to them are dropped.
   assign wr_los   = reg_write_i && (reg_addr_i == ADDR_WIDTH'(ADDR_LOS_THRESH));
   assign wr_ovr   = reg_write_i && (reg_addr_i == ADDR_WIDTH'(ADDR_DOS_OVERRANGE));
   assign wr_mis   = reg_write_i && (reg_addr_i == ADDR_WIDTH'(ADDR_DOS_MISMATCH));
   assign wr_max   = reg_write_i && (reg_addr_i == ADDR_WIDTH'(ADDR_DOS_MAX));
   assign wr_min   = reg_write_i && (reg_addr_i == ADDR_WIDTH'(ADDR_DOS_MIN));
   assign wr_mask  = reg_write_i && (reg_addr_i == ADDR_WIDTH'(ADDR_ENABLE_MASK));
   assign wr_clear = reg_write_i && (reg_addr_i == ADDR_WIDTH'(ADDR_ERROR_CLEAR));

   assign clr     = wr_clear ? reg_data_i[NUM_ERRORS-1:0] : '0;
   assign clr_all = wr_clear && reg_data_i[CLEAR_ALL_BIT];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         los_q        <= THRESH_WIDTH'(LOS_THRESH_RST);
         ovr_q        <= THRESH_WIDTH'(DOS_OVERRANGE_RST);
         mis_q        <= THRESH_WIDTH'(DOS_MISMATCH_RST);
         max_q        <= THRESH_WIDTH'(DOS_MAX_RST);
         min_q        <= THRESH_WIDTH'(DOS_MIN_RST);
         mask_q       <= '0;
         cfg_update_q <= 1'b0;
         error_q      <= '0;
      end else begin
         if (wr_los)  los_q  <= reg_data_i[THRESH_WIDTH-1:0];
         if (wr_ovr)  ovr_q  <= reg_data_i[THRESH_WIDTH-1:0];
         if (wr_mis)  mis_q  <= reg_data_i[THRESH_WIDTH-1:0];
         if (wr_max)  max_q  <= reg_data_i[THRESH_WIDTH-1:0];
         if (wr_min)  min_q  <= reg_data_i[THRESH_WIDTH-1:0];
         if (wr_mask) mask_q <= reg_data_i[NUM_ERRORS-1:0];
         // Pulses in the cycle after a threshold write, once the new value is on the outputs.
         cfg_update_q <= wr_los | wr_ovr | wr_mis | wr_max | wr_min;
         // Registered from the current sticky and mask, so status and mask changes appear one
         // cycle after the edge that made them.
         error_q <= sticky & mask_q;
      end
   end

   error_latch_bank #(
      .NUM_ERRORS  (NUM_ERRORS),
      .COUNT_WIDTH (EVENT_COUNT_WIDTH)
   ) u_latch (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .event_i       (error_event_i),
      .mask_i        (mask_q),
      .clr_i         (clr),
      .clr_all_i     (clr_all),
      .sticky_o      (sticky),
      .first_fault_o (first_fault),
      .event_count_o (event_count)
   );

   // Combinational read decode. A read in the same cycle as a write returns the old value.
   always_comb begin
      reg_data_o = '0;
      if (reg_read_i) begin
         case (reg_addr_i)
            ADDR_WIDTH'(ADDR_ID):            reg_data_o = ID_VALUE;
            ADDR_WIDTH'(ADDR_LOS_THRESH):    reg_data_o = DATA_WIDTH'(los_q);
            ADDR_WIDTH'(ADDR_DOS_OVERRANGE): reg_data_o = DATA_WIDTH'(ovr_q);
            ADDR_WIDTH'(ADDR_DOS_MISMATCH):  reg_data_o = DATA_WIDTH'(mis_q);
            ADDR_WIDTH'(ADDR_DOS_MAX):       reg_data_o = DATA_WIDTH'(max_q);
            ADDR_WIDTH'(ADDR_DOS_MIN):       reg_data_o = DATA_WIDTH'(min_q);
            ADDR_WIDTH'(ADDR_ENABLE_MASK):   reg_data_o = DATA_WIDTH'(mask_q);
            ADDR_WIDTH'(ADDR_STATUS):        reg_data_o = DATA_WIDTH'(sticky);
            ADDR_WIDTH'(ADDR_FIRST_FAULT):   reg_data_o = DATA_WIDTH'(first_fault);
            ADDR_WIDTH'(ADDR_EVENT_COUNT):   reg_data_o = DATA_WIDTH'(event_count);
            default:                         reg_data_o = '0;
         endcase
      end
   end

   assign los_thresh_o           = los_q;
   assign dos_overrange_thresh_o = ovr_q;
   assign dos_mismatch_thresh_o  = mis_q;
   assign dos_max_thresh_o       = max_q;
   assign dos_min_thresh_o       = min_q;
   assign cfg_update_o           = cfg_update_q;
   assign error_o                = error_q;

endmodule

// File: tb/tb_rdc_error_regs.sv
// Directed bench for rdc_error_regs with a queue-based expected-value scoreboard.
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled away from the edge.
// The bench has no backpressure. Every wait is a fixed number of cycles.
module tb_rdc_error_regs;
   import rdc_regs_pkg::*;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic [7:0]  reg_addr_i;
   logic [31:0] reg_data_i;
   logic        reg_write_i;
   logic        reg_read_i;
   logic [31:0] reg_data_o;
   logic [7:0]  error_event_i;
   logic [13:0] los_thresh_o, dos_overrange_thresh_o, dos_mismatch_thresh_o;
   logic [13:0] dos_max_thresh_o, dos_min_thresh_o;
   logic        cfg_update_o;
   logic [7:0]  error_o;

   int n_asserts = 0;
   int n_fail    = 0;

   string       tag_q[$];
   logic [31:0] exp_q[$];

   always #5 clk_i = ~clk_i;

   rdc_error_regs dut (
      .clk_i                  (clk_i),
      .reset_i                (reset_i),
      .reg_addr_i             (reg_addr_i),
      .reg_data_i             (reg_data_i),
      .reg_write_i            (reg_write_i),
      .reg_read_i             (reg_read_i),
      .reg_data_o             (reg_data_o),
      .error_event_i          (error_event_i),
      .los_thresh_o           (los_thresh_o),
      .dos_overrange_thresh_o (dos_overrange_thresh_o),
      .dos_mismatch_thresh_o  (dos_mismatch_thresh_o),
      .dos_max_thresh_o       (dos_max_thresh_o),
      .dos_min_thresh_o       (dos_min_thresh_o),
      .cfg_update_o           (cfg_update_o),
      .error_o                (error_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic expect_val(input string tag, input logic [31:0] val);
      tag_q.push_back(tag);
      exp_q.push_back(val);
   endtask

   task automatic compare(input logic [31:0] obs);
      string       t;
      logic [31:0] e;
      n_asserts++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_underflow observed=%h expected=none", obs);
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
         end
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      reg_addr_i  = a;
      reg_data_i  = d;
      reg_write_i = 1'b1;
      tick();
      reg_write_i = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] e);
      reg_addr_i = a;
      reg_read_i = 1'b1;
      expect_val(tag, e);
      #1;
      compare(reg_data_o);
      reg_read_i = 1'b0;
      tick();
   endtask

   logic [15:0] model_cnt;

   initial begin
      reset_i       = 1'b1;
      reg_addr_i    = '0;
      reg_data_i    = '0;
      reg_write_i   = 1'b0;
      reg_read_i    = 1'b0;
      error_event_i = '0;
      repeat (3) tick();
      reset_i = 1'b0;

      // Reset state
      expect_val("rst_error_o", 32'h0);       compare(32'(error_o));
      expect_val("rst_cfg_update", 32'h0);    compare(32'(cfg_update_o));
      expect_val("rst_los_o", 32'h0100);      compare(32'(los_thresh_o));
      expect_val("rst_min_o", 32'h1FFF);      compare(32'(dos_min_thresh_o));
      rd("rd_id", 8'h00, 32'h1234_5678);
      rd("rd_los", 8'h01, 32'h0100);
      rd("rd_ovr", 8'h02, 32'h1FFF);
      rd("rd_mis", 8'h03, 32'h1000);
      rd("rd_max", 8'h04, 32'h0000);
      rd("rd_min", 8'h05, 32'h1FFF);
      rd("rd_mask", 8'h06, 32'h0);
      rd("rd_unmapped", 8'h0B, 32'h0);
      rd("rd_status_rst", 8'h08, 32'h0);
      rd("rd_count_rst", 8'h0A, 32'h0);

      // Threshold write with a same-cycle read, which must return the old value
      reg_addr_i  = 8'h01;
      reg_data_i  = 32'hFFFF_ABCD;
      reg_write_i = 1'b1;
      reg_read_i  = 1'b1;
      expect_val("rd_during_wr_old", 32'h0100);
      #1;
      compare(reg_data_o);
      tick();
      reg_write_i = 1'b0;
      reg_read_i  = 1'b0;
      expect_val("los_o_after_wr", 32'h2BCD);  compare(32'(los_thresh_o));
      expect_val("cfg_update_hi", 32'h1);      compare(32'(cfg_update_o));
      tick();
      expect_val("cfg_update_lo", 32'h0);      compare(32'(cfg_update_o));
      rd("rd_los_new", 8'h01, 32'h2BCD);
      wr(8'h02, 32'hFFFF_FFFF);
      rd("rd_ovr_trunc", 8'h02, 32'h3FFF);
      wr(8'h00, 32'hDEAD_BEEF);
      rd("rd_id_ro", 8'h00, 32'h1234_5678);
      wr(8'h0A, 32'h0000_1234);
      rd("rd_count_ro", 8'h0A, 32'h0);
      rd("rd_clear_reads0", 8'h07, 32'h0);

      // Enabled error on bit 0
      wr(8'h06, 32'hFF);
      expect_val("cfg_update_mask", 32'h0);    compare(32'(cfg_update_o));
      error_event_i = 8'h01;
      tick();
      error_event_i = 8'h00;
      expect_val("err_o_latency0", 32'h0);     compare(32'(error_o));
      tick();
      expect_val("err_o_bit0", 32'h01);        compare(32'(error_o));
      tick();
      expect_val("err_o_bit0_hold", 32'h01);   compare(32'(error_o));
      rd("status_bit0", 8'h08, 32'h01);
      rd("ff_bit0", 8'h09, 32'h01);
      rd("count_1", 8'h0A, 32'h1);

      // A masked error latches but does not count, then a mask change exposes it
      wr(8'h07, 32'h01);
      wr(8'h06, 32'h00);
      error_event_i = 8'h02;
      tick();
      error_event_i = 8'h00;
      tick();
      expect_val("err_o_masked", 32'h0);       compare(32'(error_o));
      rd("status_bit1", 8'h08, 32'h02);
      rd("count_masked", 8'h0A, 32'h1);
      wr(8'h06, 32'h02);
      expect_val("err_o_mask_edge", 32'h0);    compare(32'(error_o));
      tick();
      expect_val("err_o_mask_bit1", 32'h02);   compare(32'(error_o));
      rd("ff_held", 8'h09, 32'h01);

      // A set beats a clear on the same bit, then a clear with the event low removes it
      wr(8'h06, 32'hFF);
      error_event_i = 8'h04;
      tick();
      wr(8'h07, 32'h04);
      rd("status_set_wins", 8'h08, 32'h06);
      rd("count_bit2", 8'h0A, 32'h2);
      error_event_i = 8'h00;
      wr(8'h07, 32'h04);
      expect_val("err_o_clr_edge", 32'h06);    compare(32'(error_o));
      tick();
      expect_val("err_o_clr_bit2", 32'h02);    compare(32'(error_o));
      rd("status_clr_bit2", 8'h08, 32'h02);

      // Saturation: alternate bits 0 and 1 so that every cycle produces one new event
      wr(8'h07, 32'h8000_00FF);
      rd("count_clr_all", 8'h0A, 32'h0);
      model_cnt = 16'h0;
      reg_addr_i  = 8'h07;
      reg_write_i = 1'b1;
      for (int i = 0; i < 65535; i++) begin
         error_event_i = (i % 2 == 0) ? 8'h01 : 8'h02;
         reg_data_i    = (i % 2 == 0) ? 32'h02 : 32'h01;
         if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'h1;
         tick();
      end
      reg_write_i   = 1'b0;
      error_event_i = 8'h00;
      rd("count_at_max", 8'h0A, 32'(model_cnt));
      rd("ff_sat_run", 8'h09, 32'h01);
      reg_addr_i  = 8'h07;
      reg_write_i = 1'b1;
      for (int i = 65535; i < 70000; i++) begin
         error_event_i = (i % 2 == 0) ? 8'h01 : 8'h02;
         reg_data_i    = (i % 2 == 0) ? 32'h02 : 32'h01;
         if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'h1;
         tick();
      end
      reg_write_i   = 1'b0;
      error_event_i = 8'h00;
      rd("count_saturated", 8'h0A, 32'(model_cnt));

      // Clear-all, then clear-all with a simultaneous new event
      wr(8'h07, 32'h8000_00FF);
      rd("status_clr_all", 8'h08, 32'h0);
      rd("ff_clr_all", 8'h09, 32'h0);
      rd("count_clr_all2", 8'h0A, 32'h0);
      error_event_i = 8'h08;
      wr(8'h07, 32'h8000_0000);
      error_event_i = 8'h00;
      rd("count_clr_vs_evt", 8'h0A, 32'h1);
      rd("ff_clr_vs_evt", 8'h09, 32'h08);

      // Reset during a pending write and event
      reset_i       = 1'b1;
      reg_addr_i    = 8'h01;
      reg_data_i    = 32'h55;
      reg_write_i   = 1'b1;
      error_event_i = 8'h01;
      tick();
      reset_i       = 1'b0;
      reg_write_i   = 1'b0;
      error_event_i = 8'h00;
      expect_val("mid_rst_los_o", 32'h0100);   compare(32'(los_thresh_o));
      expect_val("mid_rst_err_o", 32'h0);      compare(32'(error_o));
      rd("mid_rst_status", 8'h08, 32'h0);
      rd("mid_rst_count", 8'h0A, 32'h0);
      rd("mid_rst_ff", 8'h09, 32'h0);
      rd("mid_rst_mask", 8'h06, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
